// File: rtl/decode_stage_if.sv
// Fetch/decode/AGEX bundle for the LC-3b decode stage: fetch inputs, downstream
// hazard hints, writeback port, and the AGEX pipeline latch outputs.
interface decode_stage_if;
    logic        ld_de;
    logic [15:0] de_npc_in;
    logic [15:0] de_ir_in;
    logic        de_v_in;
    logic        mem_stall;
    logic        v_agex_ld_reg;
    logic [2:0]  agex_drid;
    logic        v_agex_ld_cc;
    logic        v_mem_ld_reg;
    logic [2:0]  mem_drid;
    logic        v_mem_ld_cc;
    logic        wb_ld_reg;
    logic [2:0]  wb_drid;
    logic [15:0] wb_data;
    logic        wb_ld_cc;
    logic [2:0]  wb_cc;
    logic        dep_stall;
    logic        v_de_br_stall;
    logic        agex_v;
    logic [15:0] agex_npc;
    logic [15:0] agex_ir;
    logic [15:0] agex_sr1;
    logic [15:0] agex_sr2;
    logic [2:0]  agex_cc;
    logic [2:0]  agex_drid_out;   // latched destination; agex_drid is the hazard hint input
    logic        agex_ld_reg;
    logic        agex_ld_cc;

    modport master (
        output ld_de, de_npc_in, de_ir_in, de_v_in, mem_stall,
               v_agex_ld_reg, agex_drid, v_agex_ld_cc,
               v_mem_ld_reg, mem_drid, v_mem_ld_cc,
               wb_ld_reg, wb_drid, wb_data, wb_ld_cc, wb_cc,
        input  dep_stall, v_de_br_stall, agex_v, agex_npc, agex_ir,
               agex_sr1, agex_sr2, agex_cc, agex_drid_out, agex_ld_reg, agex_ld_cc
    );

    modport slave (
        input  ld_de, de_npc_in, de_ir_in, de_v_in, mem_stall,
               v_agex_ld_reg, agex_drid, v_agex_ld_cc,
               v_mem_ld_reg, mem_drid, v_mem_ld_cc,
               wb_ld_reg, wb_drid, wb_data, wb_ld_cc, wb_cc,
        output dep_stall, v_de_br_stall, agex_v, agex_npc, agex_ir,
               agex_sr1, agex_sr2, agex_cc, agex_drid_out, agex_ld_reg, agex_ld_cc
    );
endinterface

// File: rtl/decode_stage.sv
// LC-3b decode stage: DE latch, register file with writeback bypass, condition
// codes, dependency detection and the AGEX pipeline latch.
module decode_stage #(
    parameter int          NUM_REGS = 8,
    parameter logic [2:0]  LINK_REG = 3'd7,
    parameter logic [2:0]  CC_RESET = 3'b010
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.slave  bus
);
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDW  = 4'b0110;
    localparam logic [3:0] OP_STW  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    logic [15:0] de_npc_q, de_npc_d;
    logic [15:0] de_ir_q,  de_ir_d;
    logic        de_v_q,   de_v_d;
    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] regs_d [NUM_REGS];
    logic [2:0]  cc_q, cc_d;

    logic        agex_v_q, agex_v_d;
    logic [15:0] agex_npc_q, agex_npc_d;
    logic [15:0] agex_ir_q, agex_ir_d;
    logic [15:0] agex_sr1_q, agex_sr1_d;
    logic [15:0] agex_sr2_q, agex_sr2_d;
    logic [2:0]  agex_cc_q, agex_cc_d;
    logic [2:0]  agex_drid_q, agex_drid_d;
    logic        agex_ld_reg_q, agex_ld_reg_d;
    logic        agex_ld_cc_q, agex_ld_cc_d;

    logic [3:0]  op;
    logic        use_sr1, use_sr2, is_ctrl;
    logic [2:0]  sr1_id, sr2_id, dec_drid;
    logic        dec_ld_reg, dec_ld_cc;
    logic [15:0] sr1_val, sr2_val;
    logic [2:0]  cc_val;
    logic        src_hazard, cc_hazard, dep_stall;

    always_comb begin
        op         = de_ir_q[15:12];
        sr1_id     = de_ir_q[8:6];
        sr2_id     = de_ir_q[2:0];
        use_sr1    = 1'b0;
        use_sr2    = 1'b0;
        dec_drid   = 3'd0;
        dec_ld_reg = 1'b0;
        dec_ld_cc  = 1'b0;
        is_ctrl    = 1'b0;
        case (op)
            OP_ADD, OP_AND, OP_XOR: begin
                use_sr1    = 1'b1;
                use_sr2    = !de_ir_q[5];
                dec_drid   = de_ir_q[11:9];
                dec_ld_reg = 1'b1;
                dec_ld_cc  = 1'b1;
            end
            OP_SHF, OP_LDB, OP_LDW: begin
                use_sr1    = 1'b1;
                dec_drid   = de_ir_q[11:9];
                dec_ld_reg = 1'b1;
                dec_ld_cc  = 1'b1;
            end
            OP_STB, OP_STW: begin
                use_sr1 = 1'b1;
                use_sr2 = 1'b1;
                sr2_id  = de_ir_q[11:9];
            end
            OP_LEA: begin
                dec_drid   = de_ir_q[11:9];
                dec_ld_reg = 1'b1;
            end
            OP_JSR: begin
                use_sr1    = !de_ir_q[11];
                dec_drid   = LINK_REG;
                dec_ld_reg = 1'b1;
                is_ctrl    = 1'b1;
            end
            OP_TRAP: begin
                dec_drid   = LINK_REG;
                dec_ld_reg = 1'b1;
                is_ctrl    = 1'b1;
            end
            OP_JMP: begin
                use_sr1 = 1'b1;
                is_ctrl = 1'b1;
            end
            OP_BR:   is_ctrl = 1'b1;
            default: ;
        endcase
    end

    // Same-cycle writeback is forwarded so the SR stage never needs to stall us.
    always_comb begin
        sr1_val = (bus.wb_ld_reg && bus.wb_drid == sr1_id) ? bus.wb_data : regs_q[sr1_id];
        sr2_val = (bus.wb_ld_reg && bus.wb_drid == sr2_id) ? bus.wb_data : regs_q[sr2_id];
        cc_val  = bus.wb_ld_cc ? bus.wb_cc : cc_q;
    end

    always_comb begin
        src_hazard = (use_sr1 && ((bus.v_agex_ld_reg && bus.agex_drid == sr1_id) ||
                                  (bus.v_mem_ld_reg  && bus.mem_drid  == sr1_id))) ||
                     (use_sr2 && ((bus.v_agex_ld_reg && bus.agex_drid == sr2_id) ||
                                  (bus.v_mem_ld_reg  && bus.mem_drid  == sr2_id)));
        cc_hazard  = (op == OP_BR) && (bus.v_agex_ld_cc || bus.v_mem_ld_cc);
        dep_stall  = de_v_q && (src_hazard || cc_hazard);
    end

    always_comb begin
        de_npc_d = de_npc_q;
        de_ir_d  = de_ir_q;
        de_v_d   = de_v_q;
        if (bus.ld_de) begin
            de_npc_d = bus.de_npc_in;
            de_ir_d  = bus.de_ir_in;
            de_v_d   = bus.de_v_in;
        end
        regs_d = regs_q;
        if (bus.wb_ld_reg)
            regs_d[bus.wb_drid] = bus.wb_data;
        cc_d = bus.wb_ld_cc ? bus.wb_cc : cc_q;
    end

    always_comb begin
        agex_v_d      = agex_v_q;
        agex_npc_d    = agex_npc_q;
        agex_ir_d     = agex_ir_q;
        agex_sr1_d    = agex_sr1_q;
        agex_sr2_d    = agex_sr2_q;
        agex_cc_d     = agex_cc_q;
        agex_drid_d   = agex_drid_q;
        agex_ld_reg_d = agex_ld_reg_q;
        agex_ld_cc_d  = agex_ld_cc_q;
        if (!bus.mem_stall) begin
            agex_v_d      = de_v_q && !dep_stall;
            agex_npc_d    = de_npc_q;
            agex_ir_d     = de_ir_q;
            agex_sr1_d    = sr1_val;
            agex_sr2_d    = sr2_val;
            agex_cc_d     = cc_val;
            agex_drid_d   = dec_drid;
            agex_ld_reg_d = dec_ld_reg && agex_v_d;
            agex_ld_cc_d  = dec_ld_cc && agex_v_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de_npc_q <= '0;
            de_ir_q  <= '0;
            de_v_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            cc_q          <= CC_RESET;
            agex_v_q      <= 1'b0;
            agex_npc_q    <= '0;
            agex_ir_q     <= '0;
            agex_sr1_q    <= '0;
            agex_sr2_q    <= '0;
            agex_cc_q     <= '0;
            agex_drid_q   <= '0;
            agex_ld_reg_q <= 1'b0;
            agex_ld_cc_q  <= 1'b0;
        end else begin
            de_npc_q      <= de_npc_d;
            de_ir_q       <= de_ir_d;
            de_v_q        <= de_v_d;
            regs_q        <= regs_d;
            cc_q          <= cc_d;
            agex_v_q      <= agex_v_d;
            agex_npc_q    <= agex_npc_d;
            agex_ir_q     <= agex_ir_d;
            agex_sr1_q    <= agex_sr1_d;
            agex_sr2_q    <= agex_sr2_d;
            agex_cc_q     <= agex_cc_d;
            agex_drid_q   <= agex_drid_d;
            agex_ld_reg_q <= agex_ld_reg_d;
            agex_ld_cc_q  <= agex_ld_cc_d;
        end
    end

    assign bus.dep_stall     = dep_stall;
    assign bus.v_de_br_stall = de_v_q && is_ctrl;
    assign bus.agex_v        = agex_v_q;
    assign bus.agex_npc      = agex_npc_q;
    assign bus.agex_ir       = agex_ir_q;
    assign bus.agex_sr1      = agex_sr1_q;
    assign bus.agex_sr2      = agex_sr2_q;
    assign bus.agex_cc       = agex_cc_q;
    assign bus.agex_drid_out = agex_drid_q;
    assign bus.agex_ld_reg   = agex_ld_reg_q;
    assign bus.agex_ld_cc    = agex_ld_cc_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a reference model predicts the AGEX latch
// each cycle into a scoreboard queue that is drained after the clock edge.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if bus();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct packed {
        logic        v;
        logic [15:0] npc;
        logic [15:0] ir;
        logic [15:0] sr1;
        logic [15:0] sr2;
        logic [2:0]  cc;
        logic [2:0]  drid;
        logic        ld_reg;
        logic        ld_cc;
        logic        chk_sr1;
        logic        chk_sr2;
        logic        chk_dr;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_ag;
    logic [15:0] m_regs [8];
    logic [2:0]  m_cc;
    logic [15:0] m_de_npc, m_de_ir;
    logic        m_de_v;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd(input logic [2:0] id);
        return (bus.wb_ld_reg && bus.wb_drid == id) ? bus.wb_data : m_regs[id];
    endfunction

    // Reference decode built from opcode membership masks (bit n = opcode n).
    task automatic ref_decode(input logic [15:0] ir, output logic u1, output logic u2,
                              output logic [2:0] s1, output logic [2:0] s2,
                              output logic lr, output logic lc, output logic [2:0] d);
        logic [15:0] sr1_ops, wr_ops, cc_ops;
        logic [3:0]  op;
        sr1_ops = 16'b0011_0010_1110_1110;
        wr_ops  = 16'b0110_0010_0110_0110;
        cc_ops  = 16'b0010_0010_0110_0110;
        op = ir[15:12];
        s1 = ir[8:6];
        u1 = sr1_ops[op] || (op == 4'd4 && !ir[11]);
        u2 = ((op == 4'd1 || op == 4'd5 || op == 4'd9) && !ir[5]) || op == 4'd3 || op == 4'd7;
        s2 = (op == 4'd3 || op == 4'd7) ? ir[11:9] : ir[2:0];
        lr = wr_ops[op] || op == 4'd4 || op == 4'd15;
        lc = cc_ops[op];
        d  = (op == 4'd4 || op == 4'd15) ? 3'd7 : ir[11:9];
    endtask

    task automatic step();
        exp_t        e;
        logic        u1, u2, lr, lc, haz, dep, brs;
        logic [2:0]  s1, s2, d;
        logic [3:0]  op;
        #1;
        ref_decode(m_de_ir, u1, u2, s1, s2, lr, lc, d);
        op  = m_de_ir[15:12];
        haz = 1'b0;
        if (u1 && ((bus.v_agex_ld_reg && bus.agex_drid == s1) || (bus.v_mem_ld_reg && bus.mem_drid == s1)))
            haz = 1'b1;
        if (u2 && ((bus.v_agex_ld_reg && bus.agex_drid == s2) || (bus.v_mem_ld_reg && bus.mem_drid == s2)))
            haz = 1'b1;
        if (op == 4'd0 && (bus.v_agex_ld_cc || bus.v_mem_ld_cc))
            haz = 1'b1;
        dep = m_de_v && haz;
        brs = m_de_v && (op inside {4'd0, 4'd12, 4'd4, 4'd15});
        if (!reset) begin
            check("dep_stall", {15'd0, bus.dep_stall}, {15'd0, dep});
            check("v_de_br_stall", {15'd0, bus.v_de_br_stall}, {15'd0, brs});
        end
        if (reset) begin
            m_ag = '0;
            m_ag.chk_sr1 = 1'b1;
            m_ag.chk_sr2 = 1'b1;
            m_ag.chk_dr  = 1'b1;
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_cc = 3'b010;
            m_de_npc = '0;
            m_de_ir  = '0;
            m_de_v   = 1'b0;
        end else begin
            if (!bus.mem_stall) begin
                m_ag.v       = m_de_v && !dep;
                m_ag.npc     = m_de_npc;
                m_ag.ir      = m_de_ir;
                m_ag.sr1     = rd(s1);
                m_ag.sr2     = rd(s2);
                m_ag.cc      = bus.wb_ld_cc ? bus.wb_cc : m_cc;
                m_ag.drid    = d;
                m_ag.ld_reg  = lr && m_ag.v;
                m_ag.ld_cc   = lc && m_ag.v;
                m_ag.chk_sr1 = u1;
                m_ag.chk_sr2 = u2;
                m_ag.chk_dr  = lr;
            end
            if (bus.wb_ld_reg) m_regs[bus.wb_drid] = bus.wb_data;
            if (bus.wb_ld_cc)  m_cc = bus.wb_cc;
            if (bus.ld_de) begin
                m_de_npc = bus.de_npc_in;
                m_de_ir  = bus.de_ir_in;
                m_de_v   = bus.de_v_in;
            end
        end
        sb.push_back(m_ag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("agex_v",      {15'd0, bus.agex_v},      {15'd0, e.v});
        check("agex_npc",    bus.agex_npc,             e.npc);
        check("agex_ir",     bus.agex_ir,              e.ir);
        check("agex_cc",     {13'd0, bus.agex_cc},     {13'd0, e.cc});
        check("agex_ld_reg", {15'd0, bus.agex_ld_reg}, {15'd0, e.ld_reg});
        check("agex_ld_cc",  {15'd0, bus.agex_ld_cc},  {15'd0, e.ld_cc});
        if (e.chk_sr1) check("agex_sr1", bus.agex_sr1, e.sr1);
        if (e.chk_sr2) check("agex_sr2", bus.agex_sr2, e.sr2);
        if (e.chk_dr)  check("agex_drid", {13'd0, bus.agex_drid_out}, {13'd0, e.drid});
        @(negedge clk);
    endtask

    task automatic clr_side();
        bus.mem_stall     = 1'b0;
        bus.v_agex_ld_reg = 1'b0;
        bus.agex_drid     = 3'd0;
        bus.v_agex_ld_cc  = 1'b0;
        bus.v_mem_ld_reg  = 1'b0;
        bus.mem_drid      = 3'd0;
        bus.v_mem_ld_cc   = 1'b0;
        bus.wb_ld_reg     = 1'b0;
        bus.wb_drid       = 3'd0;
        bus.wb_data       = 16'h0;
        bus.wb_ld_cc      = 1'b0;
        bus.wb_cc         = 3'd0;
    endtask

    task automatic load(input logic [15:0] ir, input logic [15:0] npc, input logic v);
        bus.ld_de     = 1'b1;
        bus.de_ir_in  = ir;
        bus.de_npc_in = npc;
        bus.de_v_in   = v;
        step();
        bus.ld_de = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.ld_de = 1'b0;
        bus.de_ir_in = '0;
        bus.de_npc_in = '0;
        bus.de_v_in = 1'b0;
        clr_side();
        m_ag = '0;
        step();
        step();
        reset = 1'b0;

        // ADD R1,R2,#3 then writeback bypass of R2 and its later plain read
        load(16'h12A3, 16'h3002, 1'b1);
        step();
        bus.wb_ld_reg = 1'b1; bus.wb_drid = 3'd2; bus.wb_data = 16'h1234;
        step();
        bus.wb_ld_reg = 1'b0;
        step();

        // ADD R3,R1,R2 with R2 pending in AGEX
        load(16'h1642, 16'h3004, 1'b1);
        bus.v_agex_ld_reg = 1'b1; bus.agex_drid = 3'd2;
        step();
        bus.v_agex_ld_reg = 1'b0;
        step();

        // BRz behind a CC writer in MEM, then CC writeback bypass
        load(16'h0402, 16'h3006, 1'b1);
        bus.v_mem_ld_cc = 1'b1;
        step();
        bus.v_mem_ld_cc = 1'b0;
        step();
        bus.wb_ld_cc = 1'b1; bus.wb_cc = 3'b100;
        step();
        bus.wb_ld_cc = 1'b0;
        step();

        // AGEX latch frozen by mem_stall for three clocks
        load(16'h1642, 16'h3008, 1'b1);
        bus.mem_stall = 1'b1;
        repeat (3) step();
        bus.mem_stall = 1'b0;
        step();

        // STW R5,R6,#0 store-source hazard, valid and invalid
        load(16'h7B80, 16'h300A, 1'b1);
        bus.v_mem_ld_reg = 1'b1; bus.mem_drid = 3'd5;
        step();
        load(16'h7B80, 16'h300C, 1'b0);
        step();
        clr_side();

        // JSR / TRAP / LEA / RTI / reserved opcodes
        load(16'h4800, 16'h3010, 1'b1);
        load(16'hF025, 16'h3012, 1'b1);
        load(16'hE5FF, 16'h3014, 1'b1);
        load(16'h8000, 16'h3016, 1'b1);
        load(16'hA123, 16'h3018, 1'b1);
        step();

        // Reset in the middle of a stall discards everything in flight
        load(16'h1642, 16'h3020, 1'b1);
        bus.mem_stall = 1'b1; bus.v_agex_ld_reg = 1'b1; bus.agex_drid = 3'd1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr_side();
        step();

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            bus.ld_de         = 1'($urandom_range(0, 1));
            bus.de_ir_in      = 16'($urandom);
            bus.de_npc_in     = 16'($urandom);
            bus.de_v_in       = ($urandom_range(0, 3) != 0);
            bus.mem_stall     = ($urandom_range(0, 4) == 0);
            bus.v_agex_ld_reg = 1'($urandom_range(0, 1));
            bus.agex_drid     = 3'($urandom);
            bus.v_agex_ld_cc  = ($urandom_range(0, 3) == 0);
            bus.v_mem_ld_reg  = 1'($urandom_range(0, 1));
            bus.mem_drid      = 3'($urandom);
            bus.v_mem_ld_cc   = ($urandom_range(0, 3) == 0);
            bus.wb_ld_reg     = 1'($urandom_range(0, 1));
            bus.wb_drid       = 3'($urandom);
            bus.wb_data       = 16'($urandom);
            bus.wb_ld_cc      = 1'($urandom_range(0, 1));
            bus.wb_cc         = 3'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
